// File: rtl/cpu_pkg.sv
// Purpose : shared types and constants for the fetch/PC sequencer and its condition evaluator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   PC_W          - program counter / instruction-address width
//   fetch_state_t - fetch sequencer states
//   cond_t        - branch condition codes carried in instr[11:9]
//   br_offset()   - sign-extended, word-scaled branch displacement
package cpu_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_AL = 3'b111
  } cond_t;

  // The 9-bit immediate counts instruction words.
  // Sign-extend it to PC width first, then shift left by one to get a byte offset.
  // The shifted-out top bit is the duplicated sign bit, so nothing is lost.
  function automatic logic [PC_W-1:0] br_offset(input logic [8:0] imm9);
    return {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Purpose : evaluates a 3-bit branch condition against the ALU Z/V/N flags.
// Latency : purely combinational, 0 cycles.
// Backpressure: none (no handshake).
//
// Ports:
//   i_cond  [2:0] condition code (cond_t encoding)
//   i_z/i_v/i_n   ALU zero / overflow / negative flags
//   o_taken       condition holds
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_z,
  input  logic       i_v,
  input  logic       i_n,
  output logic       o_taken
);

  cond_t w_cond;

  assign w_cond = cond_t'(i_cond);

  always_comb begin
    o_taken = 1'b0;
    unique case (w_cond)
      COND_NE: o_taken = !i_z;
      COND_EQ: o_taken = i_z;
      COND_GT: o_taken = !i_z && !i_n;
      COND_LT: o_taken = i_n;
      // "equal or strictly greater" reduces to Z | !N.
      COND_GE: o_taken = i_z || !i_n;
      COND_LE: o_taken = i_n || i_z;
      COND_OV: o_taken = i_v;
      COND_AL: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Purpose : fetch/PC sequencer. It requests an instruction, holds it for the decoder
//           until the core signals completion, then selects the next PC (or halts).
// Latency : fetch takes 1 cycle plus the memory wait; the new PC is on imem_addr the
//           cycle after exe_done.
// Backpressure: a fetch stalls in WAIT until imem_rdy; execution stalls in EXEC until
//           exe_done. No output depends combinationally on imem_rdy or exe_done.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/addr/rdy/data instruction memory request/response
//   instr, instr_vld      held instruction for the decoder, valid while executing
//   exe_done              core finished; halt/BEn/Br and flags are sampled this cycle
//   halt, BEn, Br         decoder controls for the current instruction
//   flag_z/v/n            ALU flags
//   br_reg                register target for BR
//   pc_plus2              PC + 2, for the PCS write-back path
//   hlt_out               core halted (absorbing until reset)
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic            instr_vld,
  input  logic            exe_done,
  input  logic            halt,
  input  logic            BEn,
  input  logic            Br,
  input  logic            flag_z,
  input  logic            flag_v,
  input  logic            flag_n,
  input  logic [PC_W-1:0] br_reg,
  output logic [PC_W-1:0] pc_plus2,
  output logic            hlt_out
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [15:0]     r_instr;
  logic [15:0]     w_instr_nxt;

  logic [PC_W-1:0] w_pc_plus2;
  logic [PC_W-1:0] w_br_target;
  logic [PC_W-1:0] w_next_pc;
  logic            w_cond_taken;

  // Next-PC datapath. It is evaluated every cycle, but it only matters when exe_done
  // is high in EXEC.
  assign w_pc_plus2  = r_pc + PC_W'(2);
  assign w_br_target = w_pc_plus2 + br_offset(r_instr[8:0]);

  branch_cond u_branch_cond (
    .i_cond  (r_instr[11:9]),
    .i_z     (flag_z),
    .i_v     (flag_v),
    .i_n     (flag_n),
    .o_taken (w_cond_taken)
  );

  // Br only picks the register target when the branch is enabled and the condition holds.
  // In every other case execution falls through.
  always_comb begin
    w_next_pc = w_pc_plus2;
    if (BEn && w_cond_taken) begin
      w_next_pc = Br ? br_reg : w_br_target;
    end
  end

  // State, PC and instruction registers. The reset branch wins over any same-cycle
  // imem_rdy, so a fetch in flight during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    imem_req    = 1'b0;
    instr_vld   = 1'b0;
    hlt_out     = 1'b0;

    unique case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          w_instr_nxt = imem_data;
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = WAIT;
        end
      end

      WAIT: begin
        // The request and the address (r_pc) are held until memory responds.
        imem_req = 1'b1;
        if (imem_rdy) begin
          w_instr_nxt = imem_data;
          w_state_nxt = EXEC;
        end
      end

      EXEC: begin
        instr_vld = 1'b1;
        if (exe_done) begin
          // halt overrides any branch. The PC stays on the HLT address.
          if (halt) begin
            w_state_nxt = HALTED;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_state_nxt = FETCH;
          end
        end
      end

      HALTED: begin
        hlt_out = 1'b1;
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign pc_plus2  = w_pc_plus2;

endmodule
